// File: rtl/uart_tx_paridad_if.sv
// Byte handshake and serial line of the UART transmitter.
// master = byte producer, slave = transmitter.
interface uart_tx_paridad_if;
    logic [7:0] data_in;
    logic       start;
    logic       ready;
    logic       done;
    logic       tx;

    modport master (
        output data_in,
        output start,
        input  ready,
        input  done,
        input  tx
    );

    modport slave (
        input  data_in,
        input  start,
        output ready,
        output done,
        output tx
    );
endinterface

// File: rtl/uart_tx_paridad.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Every bit lasts CLKS_PER_BIT clocks; tx is registered and idles high.
module uart_tx_paridad #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_tx_paridad_if.slave bus_io
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            done_q, done_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        // Per-bit timer runs in every non-idle state and wraps at the bit boundary.
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end

        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    shift_d = bus_io.data_in;
                    par_d   = (^bus_io.data_in) ^ PARITY_ODD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    assign bus_io.ready = (state_q == StIdle);
    assign bus_io.done  = done_q;
    assign bus_io.tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_paridad.sv
// Scoreboard bench: even- and odd-parity transmitters share stimulus; a line monitor
// per DUT rebuilds each frame cycle by cycle and compares it to the queued expectation.
module tb_uart_tx_paridad;

    localparam int unsigned C        = 4;
    localparam int unsigned FrameCyc = 11 * C;
    localparam int unsigned Period   = 11 * C + 1;

    typedef struct {
        logic [10:0] bits;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int unsigned next_ok = 0;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];

    uart_tx_paridad_if u_if0 ();
    uart_tx_paridad_if u_if1 ();

    uart_tx_paridad #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) u_dut0 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (u_if0.slave)
    );

    uart_tx_paridad #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) u_dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (u_if1.slave)
    );

    logic [1:0] tx_w, done_w, ready_w;
    assign tx_w    = {u_if1.tx, u_if0.tx};
    assign done_w  = {u_if1.done, u_if0.done};
    assign ready_w = {u_if1.ready, u_if0.ready};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line image indexed by bit time: start, d[0]..d[7], parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input bit odd);
        int   ones;
        logic p;
        ones = $countones(d);
        p    = ((ones + int'(odd)) % 2) == 1;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // One stimulus cycle; the model accepts a start only when the link is known idle.
    task automatic drive(input bit s, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        u_if0.start   = s;
        u_if1.start   = s;
        u_if0.data_in = d;
        u_if1.data_in = d;
        if (s && (cyc + 1 >= next_ok)) begin
            e.acc  = cyc + 1;
            e.bits = frame_of(d, 1'b0);
            exp_q0.push_back(e);
            e.bits = frame_of(d, 1'b1);
            exp_q1.push_back(e);
            next_ok = cyc + 1 + Period;
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   bad_tx;
        int   bad_hs;
        int   qsize;
        bit   aborted;
        bit   last;
        forever begin
            @(negedge clk);
            if (rst || tx_w[d] !== 1'b0) continue;
            qsize = (d == 0) ? exp_q0.size() : exp_q1.size();
            if (qsize == 0) begin
                check(1'b0, $sformatf("unexpected_frame_dut%0d", d), 1, 0);
                repeat (FrameCyc) @(negedge clk);
                continue;
            end
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check(cyc == e.acc + 1, $sformatf("start_latency_dut%0d", d),
                  int'(cyc), int'(e.acc + 1));
            bad_tx  = 0;
            bad_hs  = 0;
            aborted = 1'b0;
            for (int i = 0; i < int'(FrameCyc); i++) begin
                if (i > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx_w[d] !== e.bits[i / C]) bad_tx++;
                last = (i == int'(FrameCyc) - 1);
                if (done_w[d] !== last || ready_w[d] !== last) bad_hs++;
            end
            if (!aborted) begin
                check(bad_tx == 0, $sformatf("frame_bits_dut%0d_exp%03h", d, e.bits),
                      bad_tx, 0);
                check(bad_hs == 0, $sformatf("done_ready_dut%0d", d), bad_hs, 0);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        u_if0.start   = 1'b0;
        u_if1.start   = 1'b0;
        u_if0.data_in = 8'h00;
        u_if1.data_in = 8'h00;
        #1 rst = 1'b1;
        #1;
        check(tx_w == 2'b11, "reset_tx", int'(tx_w), 3);
        check(ready_w == 2'b11, "reset_ready", int'(ready_w), 3);
        check(done_w == 2'b00, "reset_done", int'(done_w), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        repeat (10) drive(1'b0, 8'h00);
        check(tx_w == 2'b11, "idle_tx", int'(tx_w), 3);

        drive(1'b1, 8'h55);
        repeat (50) drive(1'b0, 8'h00);
        drive(1'b1, 8'h01);
        repeat (50) drive(1'b0, 8'h00);

        // Start and data changes during DATA must not disturb the frame.
        drive(1'b1, 8'h3A);
        repeat (12) drive(1'b0, 8'h3A);
        drive(1'b1, 8'hFF);
        repeat (40) drive(1'b0, 8'hFF);

        // Start held high: second frame accepted in the done cycle.
        drive(1'b1, 8'hA3);
        repeat (Period) drive(1'b1, 8'h3C);
        repeat (50) drive(1'b0, 8'h00);

        // Reset during data bit 4 (line low there for 0xC6).
        drive(1'b1, 8'hC6);
        repeat (22) drive(1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        check(tx_w == 2'b11, "midframe_reset_tx", int'(tx_w), 3);
        check(ready_w == 2'b11, "midframe_reset_ready", int'(ready_w), 3);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        next_ok = 0;
        drive(1'b1, 8'h5A);
        repeat (50) drive(1'b0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) == 0, 8'($urandom));
        end
        repeat (60) drive(1'b0, 8'h00);

        for (int i = 0; i < 200 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) begin
            @(negedge clk);
        end
        check(exp_q0.size() == 0 && exp_q1.size() == 0, "drain",
              exp_q0.size() + exp_q1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
